pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage ARM core. Sequences the EXE stage and the stages around it.
- Decides per cycle whether to run, stall (load-use), flush (taken branch) or freeze (SRAM wait).
- Owns the architectural status register (SR) that the EXE stage reads as its carry source and updates through its ALU flags.
- Keeps a memory-wait watchdog and a stall-cycle counter for debug.

Parameters:
- MAX_WAIT, 16, memory-wait cycles tolerated before mem_timeout is raised (1..255).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- branch_taken  input  1  EXE holds a valid branch whose condition passed.
- hazard  input  1  load-use hazard reported by the hazard detector (ID needs a register that EXE is loading).
- mem_req  input  1  MEM stage holds a valid load or store (MEM_R_EN | MEM_W_EN).
- mem_ready  input  1  SRAM controller has completed the current MEM access.
- s_en  input  1  EXE instruction is valid and has its S bit set.
- status_in  input  4  NZCV flags produced by the EXE-stage ALU.
- sr  output  4  current status register {N,Z,C,V}; feeds EXE as SR.
- freeze_pc  output  1  hold the PC.
- freeze_if_id  output  1  hold the IF/ID register.
- freeze_all  output  1  hold ID/EXE, EXE/MEM and MEM/WB; suppresses register-file and memory writes.
- flush_if_id  output  1  zero the IF/ID register.
- flush_id_exe  output  1  zero the ID/EXE register (inserts a bubble).
- pc_sel  output  1  select the branch address (Br_addr) as next PC.
- mem_timeout  output  1  sticky error: memory wait exceeded MAX_WAIT.
- stall_cnt  output  CNT_W  cycles in which the pipeline did not advance normally.

Behaviour:
- Reset (asynchronous): state=RUN, sr=4'b0000, stall_cnt=0, wait_cnt=0, mem_timeout=0. All control outputs are 0 while rst=1.
- Control outputs are combinational from the current inputs and state: zero-cycle latency, valid in the same cycle the condition appears.
- Signal priority within a cycle: mem_busy (mem_req & ~mem_ready) > branch_taken > hazard.
- mem_busy:
  - freeze_pc, freeze_if_id and freeze_all are 1; every flush output and pc_sel are 0.
  - branch_taken and hazard are ignored; they stay asserted upstream and are acted on once the pipeline unfreezes.
- branch_taken, with no mem_busy:
  - pc_sel=1, flush_if_id=1, flush_id_exe=1.
  - hazard is ignored, because the instruction it refers to is being flushed.
- hazard only: freeze_pc=1, freeze_if_id=1, flush_id_exe=1. The stall lasts exactly as many cycles as hazard stays high.
- SR update:
  - At each rising edge, sr <= status_in when s_en=1, freeze_all=0 and state != ERROR.
  - Otherwise sr holds.
  - A flush in the same cycle does not block the update, since flushes act on younger instructions.
- FSM:
  - RUN -> MEM_WAIT when mem_busy. On entry wait_cnt=1.
  - MEM_WAIT: wait_cnt increments each cycle, saturating at 255.
  - MEM_WAIT -> RUN when mem_ready=1 (or mem_req drops). wait_cnt clears.
  - MEM_WAIT -> ERROR when wait_cnt reaches MAX_WAIT and mem_ready is still 0. mem_timeout is set.
  - ERROR: freeze_pc, freeze_if_id and freeze_all are held at 1, and sr is frozen. Only rst exits this state.
- mem_ready arriving in the same cycle as mem_req completes with no freeze. State stays RUN.
- stall_cnt:
  - Increments on every cycle where freeze_pc=1 or flush_id_exe=1, excluding the ERROR state.
  - Saturates at all-ones; no wrap.
- Reset mid-wait or mid-stall: all state clears immediately, and control outputs go to 0 while rst is held.

Decomposition:
- Shared package (arm_pkg):
  - FSM state encoding: RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2.
  - NZCV bit-index constants: N=3, Z=2, C=1, V=0.
- One natural sub-module: status_reg, a 4-bit SR with load enable and async reset.
- Priority logic, FSM and counters stay in pipe_ctrl.

Test Plan:
- Reset: assert rst mid-cycle with s_en=1, status_in=4'hF -> sr=0, stall_cnt=0, all control outputs 0 immediately (asynchronous).
- Load-use: hazard=1 for 1 cycle -> freeze_pc=1, freeze_if_id=1, flush_id_exe=1 that cycle; stall_cnt goes 0->1.
- Branch with hazard: branch_taken=1 and hazard=1 together -> pc_sel=1, flush_if_id=1, flush_id_exe=1, freeze_pc=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1; branch_taken=1 throughout -> freeze_all=1 for 3 cycles with pc_sel=0; pc_sel=1 on cycle 4; state returns to RUN; stall_cnt=3.
- SR update gating: s_en=1, status_in=4'b0110 during mem_busy -> sr unchanged; next cycle with mem_ready=1 -> sr=4'b0110.
- Timeout: MAX_WAIT=4, mem_req=1, mem_ready never asserted -> mem_timeout=1 after the 4th wait cycle; freeze outputs stay at 1 until rst.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the pipeline controller.
//   state_e    : controller FSM states (RUN / MEM_WAIT / ERROR)
//   *_BIT      : bit positions of the NZCV flags inside the status register
//   WAIT_SAT   : saturation value of the memory-wait counter
package arm_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    localparam logic [7:0] WAIT_SAT = 8'd255;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and the pipeline controller.
//   master : pipeline side, drives the request/condition signals
//            (branch_taken, hazard, mem_req, mem_ready, s_en, status_in)
//            and observes the control outputs.
//   slave  : controller side, receives the conditions and drives
//            sr, freeze_*, flush_*, pc_sel, mem_timeout, stall_cnt.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             branch_taken;
    logic             hazard;
    logic             mem_req;
    logic             mem_ready;
    logic             s_en;
    logic [3:0]       status_in;

    logic [3:0]       sr;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             freeze_all;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic             pc_sel;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output branch_taken, hazard, mem_req, mem_ready, s_en, status_in,
        input  sr, freeze_pc, freeze_if_id, freeze_all, flush_if_id,
               flush_id_exe, pc_sel, mem_timeout, stall_cnt
    );

    modport slave (
        input  branch_taken, hazard, mem_req, mem_ready, s_en, status_in,
        output sr, freeze_pc, freeze_if_id, freeze_all, flush_if_id,
               flush_id_exe, pc_sel, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/status_reg.sv
// Architectural NZCV status register with load enable.
//   clk    : system clock
//   rst    : asynchronous active-high reset, clears all flags
//   load_i : capture d_i at the next rising edge
//   d_i    : new {N,Z,C,V} from the ALU
//   q_o    : current {N,Z,C,V}
module status_reg
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] sr_q;
    logic [3:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d[N_BIT] = d_i[N_BIT];
            sr_d[Z_BIT] = d_i[Z_BIT];
            sr_d[C_BIT] = d_i[C_BIT];
            sr_d[V_BIT] = d_i[V_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= 4'b0000;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: chooses run / stall / flush / freeze every
// cycle, owns the status register, watches memory waits and counts stalls.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   bus      : pipe_ctrl_if slave port (conditions in, control outputs out)
//   MAX_WAIT : consecutive memory-busy cycles tolerated before ERROR (1..255)
//   CNT_W    : width of the stall-cycle counter
module pipe_ctrl
    import arm_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       wait_nxt;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_busy;
    logic freeze_pc, freeze_if_id, freeze_all;
    logic flush_if_id, flush_id_exe, pc_sel;
    logic sr_load;

    assign mem_busy = bus.mem_req & ~bus.mem_ready;

    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        freeze_all   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        pc_sel       = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        wait_nxt     = 8'd0;
        timeout_d    = timeout_q;

        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    // Branch and hazard stay pending upstream while frozen.
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    freeze_all   = 1'b1;
                    if (state_q == RUN) begin
                        wait_nxt = 8'd1;
                    end else if (wait_q == WAIT_SAT) begin
                        wait_nxt = wait_q;
                    end else begin
                        wait_nxt = wait_q + 8'd1;
                    end
                    wait_d = wait_nxt;
                    // wait_nxt counts busy cycles including this one, so the
                    // MAX_WAIT-th consecutive busy cycle is the last tolerated.
                    if (wait_nxt >= MAX_WAIT_C) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                    if (bus.branch_taken) begin
                        // The hazarding instruction is flushed, so hazard is moot.
                        pc_sel       = 1'b1;
                        flush_if_id  = 1'b1;
                        flush_id_exe = 1'b1;
                    end else if (bus.hazard) begin
                        freeze_pc    = 1'b1;
                        freeze_if_id = 1'b1;
                        flush_id_exe = 1'b1;
                    end
                end
            end
            ERROR: begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_all   = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase

        // Registers are cleared asynchronously; also force controls quiet.
        if (rst) begin
            freeze_pc    = 1'b0;
            freeze_if_id = 1'b0;
            freeze_all   = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_exe = 1'b0;
            pc_sel       = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((state_q != ERROR) && (freeze_pc || flush_id_exe) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    // Flushes only hit younger instructions, so they never block the update.
    assign sr_load = bus.s_en & ~freeze_all & (state_q != ERROR);

    status_reg u_status_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (sr_load),
        .d_i    (bus.status_in),
        .q_o    (bus.sr)
    );

    assign bus.freeze_pc    = freeze_pc;
    assign bus.freeze_if_id = freeze_if_id;
    assign bus.freeze_all   = freeze_all;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.flush_id_exe = flush_id_exe;
    assign bus.pc_sel       = pc_sel;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // model state
    bit       m_err;
    int       m_run;
    bit [3:0] m_sr;
    int       m_stall;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_vec();
        return {bus.freeze_pc, bus.freeze_if_id, bus.freeze_all,
                bus.flush_if_id, bus.flush_id_exe, bus.pc_sel};
    endfunction

    task automatic model_reset();
        m_err   = 1'b0;
        m_run   = 0;
        m_sr    = 4'b0000;
        m_stall = 0;
    endtask

    // One clock cycle: drive at negedge, check just after, advance model
    // to what the following rising edge should produce.
    task automatic step(input logic r, input logic br, input logic hz,
                        input logic mr, input logic my, input logic se,
                        input logic [3:0] st);
        logic [5:0] e;
        bit busy;
        @(negedge clk);
        rst              = r;
        bus.branch_taken = br;
        bus.hazard       = hz;
        bus.mem_req      = mr;
        bus.mem_ready    = my;
        bus.s_en         = se;
        bus.status_in    = st;
        #1;
        if (r) model_reset();
        busy = mr && !my;
        // order: freeze_pc, freeze_if_id, freeze_all, flush_if_id, flush_id_exe, pc_sel
        if (r)           e = 6'b000000;
        else if (m_err)  e = 6'b111000;
        else if (busy)   e = 6'b111000;
        else if (br)     e = 6'b000111;
        else if (hz)     e = 6'b110010;
        else             e = 6'b000000;
        chk("ctrl", 32'(ctrl_vec()), 32'(e));
        chk("sr", 32'(bus.sr), 32'(m_sr));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_err));
        if (!r) begin
            if (!m_err && (e[5] || e[1]) && m_stall < CNT_MAX) m_stall++;
            if (se && !e[3] && !m_err) m_sr = st;
            if (busy) begin
                m_run++;
                if (m_run >= MAX_WAIT) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        bus.branch_taken = 1'b0;
        bus.hazard       = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.s_en         = 1'b0;
        bus.status_in    = 4'h0;
        model_reset();

        // reset state
        do_reset();
        do_reset();
        idle();

        // load-use for one cycle
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        idle();
        chk("loaduse_stall", 32'(bus.stall_cnt), 32'd1);

        // branch and hazard together: branch wins
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("br_haz_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("br_haz_freeze_pc", 32'(bus.freeze_pc), 32'd0);

        // memory wait with pending branch and SR write gated by freeze
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110);
            chk("memwait_pc_sel", 32'(bus.pc_sel), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
        chk("memdone_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("memdone_stall", 32'(bus.stall_cnt), 32'd3);
        chk("memdone_sr_held", 32'(bus.sr), 32'd0);
        idle();
        chk("memdone_sr", 32'(bus.sr), 32'b0110);

        // same-cycle ready: no freeze
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1001);
        chk("ready_now_freeze", 32'(bus.freeze_all), 32'd0);

        // timeout after MAX_WAIT busy cycles, then sticky freeze
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        chk("timeout", 32'(bus.mem_timeout), 32'd1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
        chk("error_freeze_all", 32'(bus.freeze_all), 32'd1);

        // asynchronous reset in the middle of a cycle
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
        @(posedge clk);
        #2;
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        rst           = 1'b1;
        #1;
        chk("async_sr", 32'(bus.sr), 32'd0);
        chk("async_stall", 32'(bus.stall_cnt), 32'd0);
        chk("async_ctrl", 32'(ctrl_vec()), 32'd0);
        model_reset();
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic mr, my;
            mr = ($urandom_range(0, 9) < 4);
            my = ($urandom_range(0, 9) < 5);
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 3),
                 mr, my,
                 ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
